// File: rtl/disp_pkg.sv
// Shared constants, state encoding and sizing helper for the display scan controller.
package disp_pkg;

    localparam int         NDIG    = 4;
    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_e;

    // One counter times both phases, so it is sized for the longer of the two.
    function automatic int cnt_width(input int refresh_div, input int blank_cycles);
        int longest;
        longest = (refresh_div > blank_cycles) ? refresh_div : blank_cycles;
        return (longest < 2) ? 1 : $clog2(longest);
    endfunction

endpackage

// File: rtl/disp_scan_ctrl_if.sv
// Producer-side valid/ready channel carrying a 16-bit hex value and 4 decimal points.
interface disp_scan_ctrl_if;

    logic [15:0] in_data;
    logic [3:0]  in_dp;
    logic        in_valid;
    logic        in_ready;

    modport master (output in_data, output in_dp, output in_valid, input in_ready);
    modport slave  (input in_data, input in_dp, input in_valid, output in_ready);

endinterface

// File: rtl/sseg_decode.sv
// Hex nibble to active-low seven-segment pattern, bit order {g,f,e,d,c,b,a}.
module sseg_decode (
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    // Pure lookup; the top feeds it the nibble of the digit about to be shown.
    always_comb begin
        seg = 7'h7F;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller.
// New values land in a shadow register and are only copied to the displayed
// value at frame end, so a frame never mixes old and new digits.
// Optional build macro: DISP_LZB_EN enables leading-zero blanking.
//
// state      | meaning
// ST_BLANK d | all anodes off for BLANK_CYCLES before digit d lights
// ST_SHOW  d | digit d lit for REFRESH_DIV cycles
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst,
    disp_scan_ctrl_if.slave    in_if,
    output logic [NDIG-1:0]    an,
    output logic [6:0]         segs,
    output logic               dp,
    output logic               frame_pulse
);

    localparam int            CW         = cnt_width(REFRESH_DIV, BLANK_CYCLES);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [1:0]    LAST_DIG   = 2'(NDIG - 1);

    scan_state_e   state_q, state_d;
    logic [1:0]    dig_q, dig_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [15:0]   act_data_q;
    logic [3:0]    act_dp_q;
    logic [19:0]   shadow_q;
    logic          full_q;
    logic          accept;
    logic          frame_end;

    logic [3:0]    nib;
    logic [6:0]    seg_dec;
    logic [3:0]    an_d;
    logic [6:0]    seg_d;
    logic          dp_d;
`ifdef DISP_LZB_EN
    logic [15:0]   upper;
`endif

    assign accept         = in_if.in_valid && !full_q;
    assign in_if.in_ready = !full_q;
    assign frame_end      = (state_q == ST_SHOW) && (dig_q == LAST_DIG) && (cnt_q == SHOW_LAST);
    assign frame_pulse    = frame_end;

    // Next phase/digit/count: counter runs up from 0 and restarts on every phase change.
    always_comb begin
        state_d = state_q;
        dig_d   = dig_q;
        cnt_d   = cnt_q + 1'b1;
        case (state_q)
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = ST_SHOW;
                    cnt_d   = '0;
                end
            end
            ST_SHOW: begin
                if (cnt_q == SHOW_LAST) begin
                    state_d = ST_BLANK;
                    dig_d   = dig_q + 2'd1;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_BLANK;
                cnt_d   = '0;
            end
        endcase
    end

    // Pin values for the phase being entered; active value cannot change inside a frame.
    always_comb begin
        nib   = act_data_q[{dig_d, 2'b00} +: 4];
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
`ifdef DISP_LZB_EN
        upper = act_data_q >> {dig_d, 2'b00};
`endif
        if (state_d == ST_SHOW) begin
            an_d  = ~(4'b0001 << dig_d);
            seg_d = seg_dec;
            dp_d  = ~act_dp_q[dig_d];
`ifdef DISP_LZB_EN
            if ((dig_d != 2'd0) && (upper == 16'h0000) && !act_dp_q[dig_d]) begin
                seg_d = SEG_OFF;
            end
`endif
        end
    end

    sseg_decode u_dec (
        .nib (nib),
        .seg (seg_dec)
    );

    // Scan state and registered pin drivers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_BLANK;
            dig_q   <= '0;
            cnt_q   <= '0;
            an      <= AN_OFF;
            segs    <= SEG_OFF;
            dp      <= 1'b1;
        end else begin
            state_q <= state_d;
            dig_q   <= dig_d;
            cnt_q   <= cnt_d;
            an      <= an_d;
            segs    <= seg_d;
            dp      <= dp_d;
        end
    end

    // Shadow capture on handshake, commit to the active value only at frame end.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q   <= '0;
            full_q     <= 1'b0;
            act_data_q <= '0;
            act_dp_q   <= '0;
        end else if (accept) begin
            shadow_q <= {in_if.in_dp, in_if.in_data};
            full_q   <= 1'b1;
        end else if (frame_end && full_q) begin
            act_dp_q   <= shadow_q[19:16];
            act_data_q <= shadow_q[15:0];
            full_q     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl: per-frame expected digits go through a scoreboard queue.
module tb_disp_scan_ctrl;

    localparam int RDIV  = 8;
    localparam int BLK   = 2;
    localparam int SLOT  = RDIV + BLK;
    localparam int FRAME = 4 * SLOT;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] an;
    logic [6:0] segs;
    logic       dp;
    logic       frame_pulse;

    disp_scan_ctrl_if bus ();

    disp_scan_ctrl #(
        .REFRESH_DIV  (RDIV),
        .BLANK_CYCLES (BLK)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_if       (bus),
        .an          (an),
        .segs        (segs),
        .dp          (dp),
        .frame_pulse (frame_pulse)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [19:0] m_active;
    logic [19:0] m_shadow;
    logic        m_full;
    logic [19:0] req_q[$];
    logic [7:0]  sb_q[$];

    function automatic logic [6:0] tb_hex7(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  4'hF: return 7'h0E;
            default: return 7'h7F;
        endcase
    endfunction

    // {dp pin, segs pins} expected while digit d of value v is lit.
    function automatic logic [7:0] exp_digit(input logic [19:0] v, input int d);
        logic [15:0] val;
        logic [15:0] up;
        logic [3:0]  dpv;
        logic [6:0]  s;
        val = v[15:0];
        dpv = v[19:16];
        up  = val >> (4 * d);
        s   = tb_hex7(up[3:0]);
`ifdef DISP_LZB_EN
        if (d > 0 && up == 16'h0000 && !dpv[d]) s = 7'h7F;
`endif
        return {~dpv[d], s};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive the producer for the coming edge and advance the reference model.
    task automatic producer(input int c, input int ld_c, input logic [19:0] ld_val,
                            input int ld2_c, input logic [19:0] ld2_val);
        if (c == ld_c)  req_q.push_back(ld_val);
        if (c == ld2_c) req_q.push_back(ld2_val);
        if (req_q.size() > 0) begin
            bus.in_valid = 1'b1;
            {bus.in_dp, bus.in_data} = req_q[0];
        end else begin
            bus.in_valid = 1'b0;
        end
        if (bus.in_valid && !m_full) begin
            m_shadow = req_q.pop_front();
            m_full   = 1'b1;
        end else if (c == FRAME - 1 && m_full) begin
            m_active = m_shadow;
            m_full   = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_dp    = '0;
        req_q.delete();
        sb_q.delete();
        m_active = '0;
        m_shadow = '0;
        m_full   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_an", an, 4'hF);
            chk("rst_segs", segs, 7'h7F);
            chk("rst_dp", dp, 1'b1);
            chk("rst_in_ready", bus.in_ready, 1'b1);
            chk("rst_frame_pulse", frame_pulse, 1'b0);
        end
        rst = 1'b0;
    endtask

    // Observe one frame (cycle first_c .. FRAME-1, or until stop_c) against the model.
    task automatic observe_frame(input int first_c, input int ld_c, input logic [19:0] ld_val,
                                 input int ld2_c, input logic [19:0] ld2_val, input int stop_c);
        logic [7:0] cur;
        logic [3:0] exp_an;
        int         pos;
        int         dg;
        cur = 8'hFF;
        for (int d = 0; d < 4; d++) sb_q.push_back(exp_digit(m_active, d));
        for (int c = first_c; c < FRAME; c++) begin
            @(negedge clk);
            pos = c % SLOT;
            dg  = c / SLOT;
            chk("in_ready", bus.in_ready, !m_full);
            chk("frame_pulse", frame_pulse, (c == FRAME - 1));
            if (pos < BLK) begin
                chk("an_blank", an, 4'hF);
                chk("segs_blank", segs, 7'h7F);
                chk("dp_blank", dp, 1'b1);
            end else begin
                if (pos == BLK) begin
                    chk("sb_nonempty", (sb_q.size() > 0), 1'b1);
                    if (sb_q.size() > 0) cur = sb_q.pop_front();
                end
                exp_an = ~(4'b0001 << dg);
                chk("an_show", an, exp_an);
                chk("segs_show", segs, cur[6:0]);
                chk("dp_show", dp, cur[7]);
            end
            producer(c, ld_c, ld_val, ld2_c, ld2_val);
            if (c == stop_c) break;
        end
    endtask

    initial begin
        do_reset();
        // Free-running frame after reset shows 0000.
        observe_frame(1, -1, '0, -1, '0, -1);
        // Load 1234 mid-frame, then offer ABCD while the shadow is still full.
        observe_frame(0, 10, {4'b0001, 16'h1234}, 20, {4'b0000, 16'hABCD}, -1);
        observe_frame(0, -1, '0, -1, '0, -1);
        observe_frame(0, -1, '0, -1, '0, -1);
        // Reset while 5555 sits in the shadow.
        observe_frame(0, 10, {4'b0000, 16'h5555}, -1, '0, 25);
        do_reset();
        observe_frame(1, -1, '0, -1, '0, -1);
        // Leading-zero case.
        observe_frame(0, 3, {4'b0000, 16'h0042}, -1, '0, -1);
        observe_frame(0, -1, '0, -1, '0, -1);
        chk("sb_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
